// File: rtl/pmp_pkg.sv
// Shared PMP CSR definitions: CSR addresses, cfg byte fields, A-mode encodings,
// scan FSM states and the pmpaddr vector type driven to the checker.
package pmp_pkg;

    localparam int unsigned PMP_MAX_ENTRIES = 16;
    localparam int unsigned PMP_MSB_MAX     = 55;
    // pmpaddr holds address bits [PMP_MSB_MAX:2] plus one carry bit that is kept at 0
    localparam int unsigned PMPADDR_W       = PMP_MSB_MAX;

    localparam logic [11:0] PMPCFG0_ADDR    = 12'h3A0;
    localparam logic [11:0] PMPCFG2_ADDR    = 12'h3A2;
    localparam logic [11:0] PMPADDR0_ADDR   = 12'h3B0;
    localparam logic [11:0] PMP_ERRCNT_ADDR = 12'h7C0;

    localparam int unsigned CFG_R    = 0;
    localparam int unsigned CFG_W    = 1;
    localparam int unsigned CFG_X    = 2;
    localparam int unsigned CFG_A_LO = 3;
    localparam int unsigned CFG_A_HI = 4;
    localparam int unsigned CFG_L    = 7;

    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SCAN
    } pmp_state_e;

    typedef logic [PMP_MAX_ENTRIES-1:0][PMPADDR_W-1:0] pmpaddr_vec_type;

    // NAPOT with granularity g needs address bits [g-2:0] all set
    function automatic logic napot_aligned(input logic [PMPADDR_W-1:0] addr,
                                           input int unsigned g);
        logic ok;
        ok = 1'b1;
        for (int unsigned b = 0; b < PMPADDR_W; b++) begin
            if ((b + 1 < g) && !addr[b]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/pmp_cfg_legalize.sv
// WARL legalization of one pmpcfg byte against its current value, plus a flag
// for an attempted change to a locked byte.
module pmp_cfg_legalize
    import pmp_pkg::*;
#(
    parameter int unsigned pmp_g      = 10,
    parameter int unsigned pmp_no_tor = 0
) (
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] legal_byte,
    output logic       lock_viol
);

    logic [7:0] b;

    always_comb begin
        b = new_byte;
        b[6:5] = 2'b00;
        if (!b[CFG_R] && b[CFG_W]) b[CFG_W] = 1'b0;
        if ((b[CFG_A_HI:CFG_A_LO] == A_NA4) && (pmp_g > 0))
            b[CFG_A_HI:CFG_A_LO] = old_byte[CFG_A_HI:CFG_A_LO];
        if ((b[CFG_A_HI:CFG_A_LO] == A_TOR) && (pmp_no_tor != 0))
            b[CFG_A_HI:CFG_A_LO] = old_byte[CFG_A_HI:CFG_A_LO];
        if (old_byte[CFG_L]) b = old_byte;
        legal_byte = b;
        lock_viol  = old_byte[CFG_L] && (new_byte != old_byte);
    end

endmodule

// File: rtl/pmp_csr_file.sv
// PMP CSR storage with WARL/lock handling and a post-write legality scan.
// Optional macro PMP_CSR_ERR_CNT_EN adds a saturating dropped-write counter (clear via CSR 0x7C0).
module pmp_csr_file
    import pmp_pkg::*;
#(
    parameter int unsigned pmp_entries = 16,
    parameter int unsigned pmp_g       = 10,
    parameter int unsigned pmp_msb     = 55,
    parameter int unsigned pmp_no_tor  = 0
) (
    input  logic            clk300p,
    input  logic            rstn,
    input  logic            csr_wvalid,
    output logic            csr_wready,
    input  logic [11:0]     csr_waddr,
    input  logic [63:0]     csr_wdata,
    input  logic [11:0]     csr_raddr,
    output logic [63:0]     csr_rdata,
    output logic [63:0]     pmpcfg0,
    output logic [63:0]     pmpcfg2,
    output pmpaddr_vec_type pmpaddr,
    output logic            cfg_stable,
    output logic            cfg_legal,
    output logic            wr_err
`ifdef PMP_CSR_ERR_CNT_EN
    ,
    output logic [7:0]      err_cnt
`endif
);

    pmp_state_e                          state_q, state_d;
    logic [3:0]                          idx_q, idx_d;
    logic [11:0]                         waddr_q, waddr_d;
    logic [63:0]                         wdata_q, wdata_d;
    logic [PMP_MAX_ENTRIES-1:0][7:0]     cfg_q, cfg_d;
    pmpaddr_vec_type                     paddr_q, paddr_d;
    logic                                acc_q, acc_d;
    logic                                legal_q, legal_d;

    logic [PMP_MAX_ENTRIES-1:0][7:0]     cfg_leg;
    logic [PMP_MAX_ENTRIES-1:0]          cfg_viol;
    logic [PMP_MAX_ENTRIES:0]            tor_lock;
    logic [PMP_MAX_ENTRIES-1:0]          addr_locked;
    logic [PMP_MAX_ENTRIES-1:0]          entry_ok;
    logic [PMPADDR_W-1:0]                addr_mask;
    logic                                waddr_hit, raddr_hit, errcnt_clr;
    logic                                wr_err_c, scan_acc;

    assign tor_lock[PMP_MAX_ENTRIES] = 1'b0;

    for (genvar e = 0; e < PMP_MAX_ENTRIES; e++) begin : g_ent
        pmp_cfg_legalize #(
            .pmp_g      (pmp_g),
            .pmp_no_tor (pmp_no_tor)
        ) u_legalize (
            .old_byte   (cfg_q[e]),
            .new_byte   (wdata_q[8*(e%8) +: 8]),
            .legal_byte (cfg_leg[e]),
            .lock_viol  (cfg_viol[e])
        );
        assign tor_lock[e]    = (e < pmp_entries) && cfg_q[e][CFG_L] &&
                                (cfg_q[e][CFG_A_HI:CFG_A_LO] == A_TOR);
        // a locked TOR entry also freezes the pmpaddr below it (its base)
        assign addr_locked[e] = cfg_q[e][CFG_L] || tor_lock[e+1];
        assign entry_ok[e]    = !((cfg_q[e][CFG_A_HI:CFG_A_LO] == A_NAPOT) && (pmp_g > 1)) ||
                                napot_aligned(paddr_q[e], pmp_g);
    end

    for (genvar b = 0; b < PMPADDR_W; b++) begin : g_mask
        assign addr_mask[b] = (b < pmp_msb - 1);
    end

    assign waddr_hit = (waddr_q[11:4] == PMPADDR0_ADDR[11:4]) && (32'(waddr_q[3:0]) < pmp_entries);
    assign raddr_hit = (csr_raddr[11:4] == PMPADDR0_ADDR[11:4]) && (32'(csr_raddr[3:0]) < pmp_entries);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        cfg_d    = cfg_q;
        paddr_d  = paddr_q;
        acc_d    = acc_q;
        legal_d  = legal_q;
        wr_err_c = 1'b0;
        scan_acc = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (csr_wvalid && !errcnt_clr) begin
                    waddr_d = csr_waddr;
                    wdata_d = csr_wdata;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_SCAN;
                idx_d   = '0;
                if ((waddr_q == PMPCFG0_ADDR) || (waddr_q == PMPCFG2_ADDR)) begin
                    for (int unsigned k = 0; k < PMP_MAX_ENTRIES; k++) begin
                        if ((k < pmp_entries) && ((k >= 8) == (waddr_q == PMPCFG2_ADDR))) begin
                            cfg_d[k] = cfg_leg[k];
                            if (cfg_viol[k]) wr_err_c = 1'b1;
                        end
                    end
                end else if (waddr_hit) begin
                    if (addr_locked[waddr_q[3:0]]) wr_err_c = 1'b1;
                    else paddr_d[waddr_q[3:0]] = wdata_q[PMPADDR_W-1:0] & addr_mask;
                end else begin
                    wr_err_c = 1'b1;
                end
            end
            ST_SCAN: begin
                scan_acc = (idx_q == '0) ? entry_ok[idx_q] : (acc_q && entry_ok[idx_q]);
                acc_d    = scan_acc;
                if (32'(idx_q) == pmp_entries - 1) begin
                    legal_d = scan_acc;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk300p or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            cfg_q   <= '0;
            paddr_q <= '0;
            acc_q   <= 1'b1;
            legal_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cfg_q   <= cfg_d;
            paddr_q <= paddr_d;
            acc_q   <= acc_d;
            legal_q <= legal_d;
        end
    end

`ifdef PMP_CSR_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    assign errcnt_clr = (csr_waddr == PMP_ERRCNT_ADDR);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == ST_IDLE) && csr_wvalid && errcnt_clr) err_cnt_d = '0;
        else if (wr_err_c && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk300p or negedge rstn) begin
        if (!rstn) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign errcnt_clr = 1'b0;
`endif

    always_comb begin
        csr_rdata = '0;
        if (csr_raddr == PMPCFG0_ADDR)      csr_rdata = cfg_q[7:0];
        else if (csr_raddr == PMPCFG2_ADDR) csr_rdata = cfg_q[15:8];
        else if (raddr_hit)                 csr_rdata = 64'(paddr_q[csr_raddr[3:0]]);
    end

    assign csr_wready = (state_q == ST_IDLE);
    assign cfg_stable = (state_q == ST_IDLE);
    assign cfg_legal  = legal_q;
    assign wr_err     = wr_err_c;
    assign pmpcfg0    = cfg_q[7:0];
    assign pmpcfg2    = cfg_q[15:8];
    assign pmpaddr    = paddr_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Directed self-checking bench for pmp_csr_file (default parameters: 16 entries, G=10).
module tb_pmp_csr_file;
    import pmp_pkg::*;

    logic            clk300p;
    logic            rstn;
    logic            csr_wvalid;
    logic            csr_wready;
    logic [11:0]     csr_waddr;
    logic [63:0]     csr_wdata;
    logic [11:0]     csr_raddr;
    logic [63:0]     csr_rdata;
    logic [63:0]     pmpcfg0;
    logic [63:0]     pmpcfg2;
    pmpaddr_vec_type pmpaddr;
    logic            cfg_stable;
    logic            cfg_legal;
    logic            wr_err;
`ifdef PMP_CSR_ERR_CNT_EN
    logic [7:0]      err_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int lat, errs;
    logic [63:0] rd_apply;

    pmp_csr_file #(
        .pmp_entries (16),
        .pmp_g       (10),
        .pmp_msb     (55),
        .pmp_no_tor  (0)
    ) dut (
        .clk300p    (clk300p),
        .rstn       (rstn),
        .csr_wvalid (csr_wvalid),
        .csr_wready (csr_wready),
        .csr_waddr  (csr_waddr),
        .csr_wdata  (csr_wdata),
        .csr_raddr  (csr_raddr),
        .csr_rdata  (csr_rdata),
        .pmpcfg0    (pmpcfg0),
        .pmpcfg2    (pmpcfg2),
        .pmpaddr    (pmpaddr),
        .cfg_stable (cfg_stable),
        .cfg_legal  (cfg_legal),
        .wr_err     (wr_err)
`ifdef PMP_CSR_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clk300p = 1'b0;
    always #5 clk300p = ~clk300p;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_hs(input logic [11:0] a, input logic [63:0] d);
        int n;
        n = 0;
        @(negedge clk300p);
        while (!csr_wready && n < 64) begin
            @(negedge clk300p);
            n++;
        end
        if (n >= 64) check("wready_timeout", {63'd0, csr_wready}, 64'd1);
        csr_waddr  = a;
        csr_wdata  = d;
        csr_wvalid = 1'b1;
        @(posedge clk300p);
        #1 csr_wvalid = 1'b0;
    endtask

    task automatic wait_done(output int l, output int e, output logic [63:0] rd);
        l  = 0;
        e  = 0;
        rd = '0;
        do begin
            @(negedge clk300p);
            l++;
            if (wr_err) e++;
            if (l == 1) rd = csr_rdata;
        end while (!cfg_stable && l < 64);
    endtask

    task automatic wr(input string tag, input logic [11:0] a, input logic [63:0] d, input int exp_errs);
        do_hs(a, d);
        wait_done(lat, errs, rd_apply);
        check({tag, "_latency"}, 64'(lat), 64'd18);
        check({tag, "_wr_err"}, 64'(errs), 64'(exp_errs));
    endtask

    initial begin
        rstn       = 1'b0;
        csr_wvalid = 1'b0;
        csr_waddr  = '0;
        csr_wdata  = '0;
        csr_raddr  = 12'h3A0;
        repeat (3) @(negedge clk300p);
        check("rst_pmpcfg0", pmpcfg0, 64'd0);
        check("rst_pmpcfg2", pmpcfg2, 64'd0);
        check("rst_pmpaddr0", 64'(pmpaddr[0]), 64'd0);
        check("rst_stable", {63'd0, cfg_stable}, 64'd1);
        check("rst_legal", {63'd0, cfg_legal}, 64'd1);
        check("rst_wr_err", {63'd0, wr_err}, 64'd0);
        check("rst_wready", {63'd0, csr_wready}, 64'd1);
        rstn = 1'b1;

        // entry0 NAPOT RWX; pmpaddr0=0 is misaligned for G=10
        wr("cfg_napot", 12'h3A0, 64'h1F, 0);
        check("cfg_napot_val", pmpcfg0, 64'h1F);
        check("cfg_napot_rd", csr_rdata, 64'h1F);
        check("cfg_napot_legal", {63'd0, cfg_legal}, 64'd0);

        wr("addr_1ff", 12'h3B0, 64'h1FF, 0);
        check("addr_1ff_val", 64'(pmpaddr[0]), 64'h1FF);
        check("addr_1ff_legal", {63'd0, cfg_legal}, 64'd1);
        wr("addr_0ff", 12'h3B0, 64'h0FF, 0);
        check("addr_0ff_legal", {63'd0, cfg_legal}, 64'd0);
        wr("addr_1ff_b", 12'h3B0, 64'h1FF, 0);
        check("addr_1ff_b_legal", {63'd0, cfg_legal}, 64'd1);

        // byte1 0x12 -> 0, byte2 0x60 -> 0, byte3 0x0B (RW TOR) kept
        wr("warl", 12'h3A0, 64'h0B60_121F, 0);
        check("warl_val", pmpcfg0, 64'h0B00_001F);
        check("warl_legal", {63'd0, cfg_legal}, 64'd1);

        wr("cfg2", 12'h3A2, 64'h07, 0);
        check("cfg2_val", pmpcfg2, 64'h07);

        wr("odd_cfg", 12'h3A1, 64'hFF, 1);
        check("odd_cfg_val", pmpcfg0, 64'h0B00_001F);
        csr_raddr = 12'h3C0;
        wr("unimpl", 12'h3C0, 64'h5, 1);
        check("unimpl_rd", csr_rdata, 64'd0);

        csr_raddr = 12'h3B2;
        wr("carry", 12'h3B2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        check("carry_val", 64'(pmpaddr[2]), 64'h003F_FFFF_FFFF_FFFF);
        check("carry_rd", csr_rdata, 64'h003F_FFFF_FFFF_FFFF);

        // entry1 locked TOR freezes pmpaddr0 and pmpaddr1
        wr("lock_tor", 12'h3A0, 64'h0B00_881F, 0);
        check("lock_tor_val", pmpcfg0, 64'h0B00_881F);
        wr("tor_drop", 12'h3B0, 64'h3FF, 1);
        check("tor_drop_val", 64'(pmpaddr[0]), 64'h1FF);
        wr("l_drop", 12'h3B1, 64'h123, 1);
        check("l_drop_val", 64'(pmpaddr[1]), 64'd0);

        wr("lock0", 12'h3A0, 64'h0B00_8880, 0);
        check("lock0_val", pmpcfg0, 64'h0B00_8880);
        wr("lock0_keep", 12'h3A0, 64'h0B00_881F, 1);
        check("lock0_keep_val", pmpcfg0, 64'h0B00_8880);
        check("lock0_legal", {63'd0, cfg_legal}, 64'd1);

        csr_raddr = 12'h3B3;
        wr("rd_apply", 12'h3B3, 64'h55, 0);
        check("rd_apply_old", rd_apply, 64'd0);
        check("rd_apply_new", csr_rdata, 64'h55);

        // wvalid held through APPLY/SCAN is only taken once back in IDLE
        do_hs(12'h3B4, 64'h77);
        csr_waddr  = 12'h3B5;
        csr_wdata  = 64'h66;
        csr_wvalid = 1'b1;
        @(negedge clk300p);
        check("hold_wready", {63'd0, csr_wready}, 64'd0);
        wait_done(lat, errs, rd_apply);
        check("hold_first_val", 64'(pmpaddr[4]), 64'h77);
        check("hold_second_pending", 64'(pmpaddr[5]), 64'd0);
        @(posedge clk300p);
        #1 csr_wvalid = 1'b0;
        wait_done(lat, errs, rd_apply);
        check("hold_second_latency", 64'(lat), 64'd18);
        check("hold_second_val", 64'(pmpaddr[5]), 64'h66);

        do_hs(12'h3B6, 64'h1FF);
        repeat (5) @(negedge clk300p);
        check("mid_scan_stable", {63'd0, cfg_stable}, 64'd0);
        rstn = 1'b0;
        #1;
        check("mid_rst_pmpcfg0", pmpcfg0, 64'd0);
        check("mid_rst_pmpaddr0", 64'(pmpaddr[0]), 64'd0);
        check("mid_rst_pmpaddr6", 64'(pmpaddr[6]), 64'd0);
        check("mid_rst_stable", {63'd0, cfg_stable}, 64'd1);
        check("mid_rst_legal", {63'd0, cfg_legal}, 64'd1);
        check("mid_rst_wr_err", {63'd0, wr_err}, 64'd0);
        @(negedge clk300p);
        rstn = 1'b1;
        @(negedge clk300p);
        check("post_rst_wready", {63'd0, csr_wready}, 64'd1);

        wr("post_rst", 12'h3A0, 64'h1F, 0);
        check("post_rst_val", pmpcfg0, 64'h1F);
        check("post_rst_legal", {63'd0, cfg_legal}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
